// File: rtl/i2c_scl_phase_gen.sv
`default_nettype none
// ============================================================================
// Module   : i2c_scl_phase_gen
// Purpose  : Four-phase I2C SCL generator. Each SCL period is 4*div clk
//            cycles split into quarters. The divider is selectable between
//            standard and fast mode at period boundaries. A slave holding SCL
//            low in the high quarter stretches the period, up to a timeout.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_scl_phase_gen #(
  parameter int STD_DIV     = 1000,
  parameter int FAST_DIV    = 250,
  parameter int CBITS       = 12,
  parameter int TIMEOUT_CYC = 40000,
  parameter int TBITS       = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena_i,
  input  logic       fast_mode_i,
  input  logic       scl_in_i,
  output logic       scl_clk_o,
  output logic       data_clk_o,
  output logic [1:0] phase_o,
  output logic       switch_range_o,
  output logic       stretching_o,
  output logic       bit_tick_o,
  output logic       stretch_timeout_o
);

  localparam logic [CBITS-1:0] STD_DIV_C   = CBITS'(STD_DIV);
  localparam logic [CBITS-1:0] FAST_DIV_C  = CBITS'(FAST_DIV);
  localparam logic [TBITS-1:0] TIMEOUT_C   = TBITS'(TIMEOUT_CYC);

  // Counter state
  logic [CBITS-1:0] cnt_q, cnt_d;
  logic [CBITS-1:0] div_q, div_d;
  logic [TBITS-1:0] tcnt_q, tcnt_d;
  logic             run_q, run_d;
  logic             timeout_q, timeout_d;

  // Registered outputs
  logic             scl_q, scl_d;
  logic             data_q, data_d;
  logic [1:0]       phase_q, phase_d;
  logic             sr_q, sr_d;
  logic             str_q, str_d;
  logic             tick_q, tick_d;

  // Helper values derived from the current count
  logic [CBITS-1:0] div_sel;
  logic [CBITS-1:0] last_cnt;
  logic [CBITS-1:0] half_cnt;
  logic [CBITS-1:0] cnt_inc;
  logic [TBITS-1:0] tcnt_inc;
  logic             hold;

  // Quarter index of count c for quarter length d, via compares (no divider)
  function automatic logic [1:0] quarter(input logic [CBITS-1:0] c,
                                         input logic [CBITS-1:0] d);
    logic [CBITS-1:0] d2;
    logic [CBITS-1:0] d3;
    d2 = d << 1;
    d3 = d2 + d;
    if (c < d)       quarter = 2'd0;
    else if (c < d2) quarter = 2'd1;
    else if (c < d3) quarter = 2'd2;
    else             quarter = 2'd3;
  endfunction

  // Next-state: counter advance, stretch hold, timeout, divider reload
  always_comb begin
    div_sel   = fast_mode_i ? FAST_DIV_C : STD_DIV_C;
    last_cnt  = (div_q << 2) - 1'b1;
    half_cnt  = div_q << 1;
    cnt_inc   = cnt_q + 1'b1;
    tcnt_inc  = tcnt_q + 1'b1;
    hold      = (quarter(cnt_q, div_q) == 2'd2) && !scl_in_i && !timeout_q;

    cnt_d     = cnt_q;
    div_d     = div_q;
    tcnt_d    = tcnt_q;
    run_d     = run_q;
    timeout_d = timeout_q;
    tick_d    = 1'b0;
    str_d     = 1'b0;

    if (!ena_i) begin
      cnt_d     = '0;
      tcnt_d    = '0;
      timeout_d = 1'b0;
      run_d     = 1'b0;
      div_d     = div_sel;
    end else if (!run_q) begin
      // First enabled cycle shows cnt=0 so the first period is a full one
      run_d = 1'b1;
      cnt_d = '0;
    end else if (hold) begin
      str_d  = 1'b1;
      tcnt_d = tcnt_inc;
      if (tcnt_inc == TIMEOUT_C) begin
        timeout_d = 1'b1;
      end
    end else if (cnt_q == last_cnt) begin
      cnt_d  = '0;
      tick_d = 1'b1;
      div_d  = div_sel;
    end else begin
      cnt_d = cnt_inc;
      if (cnt_inc == half_cnt) begin
        tcnt_d = '0;
      end
    end

    // Outputs decode the count being loaded; div_d only differs from div_q
    // when cnt_d is 0, which is quarter 0 for any divider.
    if (ena_i) begin
      phase_d = quarter(cnt_d, div_d);
      scl_d   = phase_d[1];
      data_d  = (phase_d == 2'd1) || (phase_d == 2'd2);
      sr_d    = (phase_d == 2'd2);
    end else begin
      phase_d = 2'd0;
      scl_d   = 1'b1;
      data_d  = 1'b0;
      sr_d    = 1'b0;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      div_q     <= STD_DIV_C;
      tcnt_q    <= '0;
      run_q     <= 1'b0;
      timeout_q <= 1'b0;
      scl_q     <= 1'b1;
      data_q    <= 1'b0;
      phase_q   <= 2'd0;
      sr_q      <= 1'b0;
      str_q     <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      tcnt_q    <= tcnt_d;
      run_q     <= run_d;
      timeout_q <= timeout_d;
      scl_q     <= scl_d;
      data_q    <= data_d;
      phase_q   <= phase_d;
      sr_q      <= sr_d;
      str_q     <= str_d;
      tick_q    <= tick_d;
    end
  end

  assign scl_clk_o         = scl_q;
  assign data_clk_o        = data_q;
  assign phase_o           = phase_q;
  assign switch_range_o    = sr_q;
  assign stretching_o      = str_q;
  assign bit_tick_o        = tick_q;
  assign stretch_timeout_o = timeout_q;

endmodule
`default_nettype wire
